// File: rtl/exu_lsu_pkg.sv
// Shared encodings and ISA constants for the execute-stage load/store unit.
package exu_lsu_pkg;

    localparam int ISA_WIDTH = 32;
    localparam int ISA_BYTES = ISA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RSP  = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_SIZE     = 2'b11
    } lsu_err_e;

    // An illegal size code is reported ahead of any alignment problem.
    function automatic lsu_err_e access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        lsu_err_e e;
        e = ERR_OK;
        case (size)
            SZ_HALF: if (addr_lo[0]) e = ERR_MISALIGN;
            SZ_WORD: if (addr_lo != 2'b00) e = ERR_MISALIGN;
            SZ_ILL:  e = ERR_SIZE;
            default: e = ERR_OK;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/exu_lsu_align.sv
// Byte-lane steering: store lane mask, store data replication/shift, load data shift.
module lsu_align
    import exu_lsu_pkg::*;
(
    input  logic [1:0]           size_i,
    input  logic [1:0]           addr_lo_i,
    input  logic [ISA_WIDTH-1:0] wdata_i,
    input  logic [ISA_WIDTH-1:0] rdata_i,
    output logic [ISA_BYTES-1:0] lane_mask_o,
    output logic [ISA_WIDTH-1:0] wdata_o,
    output logic [ISA_WIDTH-1:0] rdata_o
);

    logic [4:0]           shamt;
    logic [ISA_WIDTH-1:0] repl;
    logic [ISA_WIDTH-1:0] keep;

    assign shamt = {addr_lo_i, 3'b000};

    always_comb begin
        lane_mask_o = '1;
        repl        = wdata_i;
        keep        = '1;
        case (size_i)
            SZ_BYTE: begin
                lane_mask_o = 4'b0001 << addr_lo_i;
                repl        = {4{wdata_i[7:0]}};
                keep        = 32'h0000_00FF;
            end
            SZ_HALF: begin
                lane_mask_o = 4'b0011 << addr_lo_i;
                repl        = {2{wdata_i[15:0]}};
                keep        = 32'h0000_FFFF;
            end
            default: ;
        endcase
    end

    assign wdata_o = repl << shamt;
    assign rdata_o = (rdata_i >> shamt) & keep;

endmodule

// File: rtl/exu_lsu.sv
// Load/store unit: accepts one access at a time, issues a single word-aligned bus
// request, waits for the load response (bounded by TIMEOUT) and reports completion.
module exu_lsu
    import exu_lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_store,
    input  logic [1:0]           size,
    input  logic [ISA_WIDTH-1:0] addr,
    input  logic [ISA_WIDTH-1:0] wdata,
    output logic                 out_valid,
    output logic [ISA_WIDTH-1:0] mem_r,
    output logic [1:0]           err,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic                 req_wen,
    output logic [ISA_WIDTH-1:0] req_addr,
    output logic [ISA_WIDTH-1:0] req_wdata,
    output logic [ISA_BYTES-1:0] req_wmask,
    input  logic                 rsp_valid,
    input  logic [ISA_WIDTH-1:0] rsp_rdata
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 req_valid_q;
    logic                 is_store_q;
    lsu_err_e             err_q;
    logic [ISA_WIDTH-1:0] mem_r_q;
    logic [1:0]           size_q;
    logic [ISA_WIDTH-1:0] addr_q;
    logic [ISA_WIDTH-1:0] wdata_q;

    lsu_err_e             acc_err;
    logic [ISA_BYTES-1:0] lane_mask;
    logic [ISA_WIDTH-1:0] wdata_al;
    logic [ISA_WIDTH-1:0] rdata_al;

    assign acc_err = access_err(size, addr[1:0]);

    // Payload is captured once at acceptance so the bus request stays stable while stalled.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready_q) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            size_q  <= size;
        end
    end

    lsu_align u_align (
        .size_i      (size_q),
        .addr_lo_i   (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .rdata_i     (rsp_rdata),
        .lane_mask_o (lane_mask),
        .wdata_o     (wdata_al),
        .rdata_o     (rdata_al)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            req_valid_q <= 1'b0;
            is_store_q  <= 1'b0;
            err_q       <= ERR_OK;
            mem_r_q     <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        is_store_q <= is_store;
                        in_ready_q <= 1'b0;
                        if (acc_err != ERR_OK) begin
                            err_q       <= acc_err;
                            mem_r_q     <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            req_valid_q <= 1'b1;
                            state_q     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (req_ready) begin
                        req_valid_q <= 1'b0;
                        if (is_store_q) begin
                            err_q       <= ERR_OK;
                            mem_r_q     <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= ST_RSP;
                        end
                    end
                end
                ST_RSP: begin
                    // A response in the final wait cycle still beats the timeout.
                    if (rsp_valid) begin
                        err_q       <= ERR_OK;
                        mem_r_q     <= rdata_al;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q       <= ERR_TIMEOUT;
                        mem_r_q     <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    in_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign mem_r     = mem_r_q;
    assign req_valid = req_valid_q;
    assign req_wen   = is_store_q;
    assign req_addr  = {addr_q[ISA_WIDTH-1:2], 2'b00};
    assign req_wdata = wdata_al;
    assign req_wmask = is_store_q ? lane_mask : '0;

endmodule

// File: tb/tb_exu_lsu.sv
// Directed bench for exu_lsu with a per-cycle comparison against a transaction-level model.
module tb_exu_lsu;

    localparam int TIMEOUT = 255;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        is_store;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        out_valid;
    logic [31:0] mem_r;
    logic [1:0]  err;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    exu_lsu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_store  (is_store),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .out_valid (out_valid),
        .mem_r     (mem_r),
        .err       (err),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Current transaction plan, expressed in cycle numbers
    int          p_c    = -100;
    int          p_d    = 0;
    int          p_done = -100;
    bit          p_req  = 1'b0;
    bit          p_st   = 1'b0;
    bit          p_chkm = 1'b0;
    logic [1:0]  p_err  = 2'b00;
    logic [31:0] p_addr = '0;
    logic [31:0] p_wdat = '0;
    logic [31:0] p_mem  = '0;
    logic [3:0]  p_mask = '0;

    // Observations used by the literal checks
    int          rv_cnt  = 0;
    int          ov_cyc  = -1;
    logic [31:0] o_addr  = '0;
    logic [31:0] o_wdata = '0;
    logic [3:0]  o_mask  = '0;
    logic [1:0]  o_err   = '0;
    logic [31:0] o_mem   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [1:0] m_err(input logic [1:0] sz, input int lo);
        if (sz == 2'b11) return 2'b11;
        if ((lo % nbytes(sz)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_mask(input bit st, input logic [1:0] sz, input int lo);
        logic [3:0] m;
        m = '0;
        if (st)
            for (int i = 0; i < 4; i++)
                if (i >= lo && i < lo + nbytes(sz)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input int lo, input logic [31:0] wd);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            if (i >= lo) w[8*i +: 8] = wd[8*((i - lo) % nbytes(sz)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] sz, input int lo, input logic [31:0] rd);
        logic [63:0] t;
        t = {32'h0, rd} >> (8 * lo);
        if (nbytes(sz) < 4) t = t & ((64'd1 << (8 * nbytes(sz))) - 64'd1);
        return t[31:0];
    endfunction

    task automatic cycle_check();
        bit e_rv, e_ov, e_ir;
        e_ir = !(cyc >= p_c + 1 && cyc <= p_done);
        e_ov = (cyc == p_done);
        e_rv = p_req && cyc >= p_c + 1 && cyc <= p_c + 1 + p_d;
        chk("in_ready", 32'(in_ready), 32'(e_ir));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("req_valid", 32'(req_valid), 32'(e_rv));
        if (req_valid) begin
            rv_cnt++;
            o_addr  = req_addr;
            o_wdata = req_wdata;
            o_mask  = req_wmask;
        end
        if (e_rv && req_valid) begin
            chk("req_addr", req_addr, p_addr);
            chk("req_wmask", 32'(req_wmask), 32'(p_mask));
            chk("req_wen", 32'(req_wen), 32'(p_st));
            if (p_st) chk("req_wdata", req_wdata, p_wdat);
        end
        if (out_valid) begin
            ov_cyc = cyc;
            o_err  = err;
            o_mem  = mem_r;
        end
        if (e_ov && out_valid) begin
            chk("err", 32'(err), 32'(p_err));
            if (p_chkm) chk("mem_r", mem_r, p_mem);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle_check();
    endtask

    // r < 0: the response never arrives. Returns the cycle in which the request was accepted.
    task automatic run_txn(input bit st, input logic [1:0] sz, input logic [31:0] ad,
                           input logic [31:0] wd, input int d, input int r,
                           input logic [31:0] rd, output int acc);
        int lo;
        lo     = int'(ad[1:0]);
        p_c    = cyc;
        p_d    = d;
        p_st   = st;
        p_err  = m_err(sz, lo);
        p_req  = (p_err == 2'b00);
        p_addr = ad & 32'hFFFF_FFFC;
        p_mask = m_mask(st, sz, lo);
        p_wdat = m_wdata(sz, lo, wd);
        if (!p_req) p_done = p_c + 1;
        else if (st) p_done = p_c + 2 + d;
        else if (r < 0) begin
            p_done = p_c + 2 + d + TIMEOUT;
            p_err  = 2'b10;
        end else p_done = p_c + 3 + d + r;
        p_chkm = !st && (p_err == 2'b00 || p_err == 2'b10);
        p_mem  = (p_err == 2'b00) ? m_rdata(sz, lo, rd) : 32'h0;
        rv_cnt = 0;
        acc    = cyc;
        in_valid  = 1'b1;
        is_store  = st;
        size      = sz;
        addr      = ad;
        wdata     = wd;
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_rdata = $urandom;
        tick();
        in_valid = 1'b0;
        is_store = 1'($urandom);
        size     = 2'($urandom);
        addr     = $urandom;
        wdata    = $urandom;
        while (cyc < p_done) begin
            req_ready = (cyc >= p_c + 1 + d);
            if (cyc <= p_c + 1 + d) begin
                rsp_valid = 1'b1;
                rsp_rdata = $urandom;
            end else begin
                rsp_valid = (r >= 0 && cyc == p_c + 2 + d + r);
                rsp_rdata = rsp_valid ? rd : $urandom;
            end
            tick();
        end
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        logic [7:0] hi;
        rst       = 1'b1;
        in_valid  = 1'b0;
        is_store  = 1'b0;
        size      = 2'b00;
        addr      = '0;
        wdata     = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_req_valid", 32'(req_valid), 32'h0);
        chk("rst_req_wen", 32'(req_wen), 32'h0);
        chk("rst_req_wmask", 32'(req_wmask), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_mem_r", mem_r, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();

        // Store byte to the top lane
        run_txn(1'b1, 2'b00, 32'h8000_0003, 32'h0000_00AB, 0, 0, 32'h0, acc);
        hi = o_wdata[31:24];
        chk("t1_wmask", 32'(o_mask), 32'h8);
        chk("t1_wdata_hi", 32'(hi), 32'hAB);
        chk("t1_addr", o_addr, 32'h8000_0000);
        chk("t1_latency", 32'(ov_cyc - acc), 32'd2);
        chk("t1_err", 32'(o_err), 32'h0);

        // Load half from the upper half, response after 3 wait cycles
        run_txn(1'b0, 2'b01, 32'h8000_0002, 32'h0, 0, 3, 32'h1234_5678, acc);
        chk("t2_mem_r", o_mem, 32'h0000_1234);
        chk("t2_err", 32'(o_err), 32'h0);
        chk("t2_latency", 32'(ov_cyc - acc), 32'd6);

        // Misaligned word load
        run_txn(1'b0, 2'b10, 32'h8000_0001, 32'h0, 0, 0, 32'h0, acc);
        chk("t3_no_req", 32'(rv_cnt), 32'd0);
        chk("t3_latency", 32'(ov_cyc - acc), 32'd1);
        chk("t3_err", 32'(o_err), 32'h1);

        // Load byte, immediate response: minimum load latency
        run_txn(1'b0, 2'b00, 32'h8000_0001, 32'h0, 0, 0, 32'hA1B2_C3D4, acc);
        chk("t4_mem_r", o_mem, 32'h0000_00C3);
        chk("t4_latency", 32'(ov_cyc - acc), 32'd3);

        // Word load, no response ever
        run_txn(1'b0, 2'b10, 32'h8000_0008, 32'h0, 0, -1, 32'h0, acc);
        chk("t5_latency", 32'(ov_cyc - acc), 32'(2 + TIMEOUT));
        chk("t5_err", 32'(o_err), 32'h2);
        chk("t5_mem_r", o_mem, 32'h0);

        // Store word with req_ready low for 5 cycles
        run_txn(1'b1, 2'b10, 32'h8000_0004, 32'hDEAD_BEEF, 5, 0, 32'h0, acc);
        chk("t6_req_cycles", 32'(rv_cnt), 32'd6);
        chk("t6_wdata", o_wdata, 32'hDEAD_BEEF);
        chk("t6_wmask", 32'(o_mask), 32'hF);
        chk("t6_latency", 32'(ov_cyc - acc), 32'd7);

        // Store half to the upper half, one stall cycle
        run_txn(1'b1, 2'b01, 32'h8000_0002, 32'h1111_CAFE, 1, 0, 32'h0, acc);
        chk("t7_wdata", o_wdata, 32'hCAFE_0000);
        chk("t7_wmask", 32'(o_mask), 32'hC);

        // Illegal size and misaligned half store
        run_txn(1'b0, 2'b11, 32'h8000_0000, 32'h0, 0, 0, 32'h0, acc);
        chk("t8_err", 32'(o_err), 32'h3);
        run_txn(1'b1, 2'b01, 32'h8000_0003, 32'h0000_BEEF, 0, 0, 32'h0, acc);
        chk("t9_err", 32'(o_err), 32'h1);
        chk("t9_no_req", 32'(rv_cnt), 32'd0);

        // Response in the last allowed wait cycle wins over the timeout
        run_txn(1'b0, 2'b10, 32'h8000_000C, 32'h0, 0, TIMEOUT - 1, 32'h55AA_00FF, acc);
        chk("t10_err", 32'(o_err), 32'h0);
        chk("t10_mem_r", o_mem, 32'h55AA_00FF);
        chk("t10_latency", 32'(ov_cyc - acc), 32'(2 + TIMEOUT));

        // Reset while waiting for a load response, then a late response
        p_c    = cyc;
        p_d    = 0;
        p_req  = 1'b1;
        p_st   = 1'b0;
        p_chkm = 1'b0;
        p_err  = 2'b10;
        p_addr = 32'h8000_0010;
        p_mask = 4'h0;
        p_done = cyc + 2 + TIMEOUT;
        in_valid = 1'b1;
        is_store = 1'b0;
        size     = 2'b10;
        addr     = 32'h8000_0010;
        tick();
        in_valid  = 1'b0;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        chk("rst2_in_ready", 32'(in_ready), 32'h1);
        chk("rst2_out_valid", 32'(out_valid), 32'h0);
        chk("rst2_req_valid", 32'(req_valid), 32'h0);
        chk("rst2_err", 32'(err), 32'h0);
        chk("rst2_mem_r", mem_r, 32'h0);
        p_c    = -100;
        p_done = -100;
        p_req  = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        rsp_valid = 1'b1;
        rsp_rdata = 32'hFFFF_FFFF;
        tick();
        rsp_valid = 1'b0;
        repeat (3) tick();
        chk("rst2_mem_r_after", mem_r, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
